// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point multiplier.
//   state_t            : controller states
//   RM_RNE / RM_RTZ    : rounding-mode encodings carried on the rm input
//   fp_bias            : exponent bias for a given exponent width
//   fp_inf/qnan/max    : positive bit patterns, returned in a 64-bit word;
//                        callers keep the low EXP_W+MAN_W+1 bits
package fp_pkg;

    typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic logic [63:0] fp_inf(input int ew, input int mw);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < ew; i++) r[mw + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] fp_qnan(input int ew, input int mw);
        logic [63:0] r;
        r = fp_inf(ew, mw);
        r[mw - 1] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] fp_max(input int ew, input int mw);
        logic [63:0] r;
        r = fp_inf(ew, mw);
        r[mw] = 1'b0;
        for (int i = 0; i < mw; i++) r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for fp_mul_seq.
//   in_valid/in_ready  : operand transfer (a, b, rm)
//   out_valid/out_ready: result transfer (c + exception flags)
// master = producer of operands / consumer of results; slave = multiplier.
interface fp_mul_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic         overflow;
    logic         underflow;
    logic         invalid;
    logic         inexact;

    modport master (
        output in_valid, a, b, rm, out_ready,
        input  in_ready, out_valid, c, overflow, underflow, invalid, inexact
    );

    modport slave (
        input  in_valid, a, b, rm, out_ready,
        output in_ready, out_valid, c, overflow, underflow, invalid, inexact
    );
endinterface

// File: rtl/fp_round_norm.sv
// Combinational back end of the multiplier: takes the captured operands and
// the raw significand product, normalises, rounds, adjusts the exponent,
// applies special-value overrides and produces the exception flags.
//   a, b     : captured operands (used for sign, exponents, class)
//   rm       : rounding mode (RM_RNE / RM_RTZ)
//   prod     : 2*(MAN_W+1)-bit significand product
//   c, flags : final result and overflow/underflow/invalid/inexact
module fp_round_norm
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0]       a,
    input  logic [EXP_W+MAN_W:0]       b,
    input  logic                       rm,
    input  logic [2*(MAN_W+1)-1:0]     prod,
    output logic [EXP_W+MAN_W:0]       c,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       invalid,
    output logic                       inexact
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int EW2 = EXP_W + 2;
    localparam int BIAS = fp_bias(EXP_W);

    localparam logic [63:0]          INF64  = fp_inf(EXP_W, MAN_W);
    localparam logic [63:0]          QNAN64 = fp_qnan(EXP_W, MAN_W);
    localparam logic [63:0]          MAX64  = fp_max(EXP_W, MAN_W);
    localparam logic [W-1:0]         INF_P  = INF64[W-1:0];
    localparam logic [W-1:0]         QNAN_P = QNAN64[W-1:0];
    localparam logic [W-1:0]         MAX_P  = MAX64[W-1:0];
    localparam logic signed [EW2-1:0] EMAX  = EW2'((1 << EXP_W) - 1);

    logic [EXP_W-1:0]      ea, eb;
    logic [MAN_W-1:0]      fa, fb;
    logic                  sign;
    logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [EW2-1:0] e0, e1, e2;
    logic [MAN_W-1:0]      frac, frac_r;
    logic                  g, st, inc, carry;

    assign ea   = a[W-2:MAN_W];
    assign eb   = b[W-2:MAN_W];
    assign fa   = a[MAN_W-1:0];
    assign fb   = b[MAN_W-1:0];
    assign sign = a[W-1] ^ b[W-1];

    // Denormal encodings (exp == 0) are classed as zero.
    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    assign a_zero = !(|ea);
    assign b_zero = !(|eb);

    always_comb begin
        c         = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        invalid   = 1'b0;
        inexact   = 1'b0;

        e0 = $signed({2'b00, ea}) + $signed({2'b00, eb}) - EW2'(BIAS);

        // Product of two [1,2) significands lies in [1,4): the top bit
        // decides whether the leading one sits at PW-1 or PW-2.
        if (prod[PW-1]) begin
            frac = prod[PW-2:SW];
            g    = prod[SW-1];
            st   = |prod[SW-2:0];
            e1   = e0 + EW2'(1);
        end else begin
            frac = prod[PW-3:SW-1];
            g    = prod[SW-2];
            st   = |prod[SW-3:0];
            e1   = e0;
        end

        inc = (rm == RM_RNE) && g && (st || frac[0]);
        {carry, frac_r} = {1'b0, frac} + SW'(inc);
        // On carry-out frac_r is already all zeros; only the exponent moves.
        e2 = carry ? e1 + EW2'(1) : e1;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            c       = QNAN_P;
            invalid = 1'b1;
        end else if (a_inf || b_inf) begin
            c = {sign, INF_P[W-2:0]};
        end else if (a_zero || b_zero) begin
            c = {sign, {(W-1){1'b0}}};
        end else if (!e2[EW2-1] && (e2 >= EMAX)) begin
            c        = (rm == RM_RTZ) ? {sign, MAX_P[W-2:0]} : {sign, INF_P[W-2:0]};
            overflow = 1'b1;
            inexact  = 1'b1;
        end else if (e2[EW2-1] || (e2 == '0)) begin
            c         = {sign, {(W-1){1'b0}}};
            underflow = 1'b1;
            inexact   = 1'b1;
        end else begin
            c       = {sign, e2[EXP_W-1:0], frac_r};
            inexact = g || st;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative floating-point multiplier, one operation in flight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_mul_seq_if slave (operands in, result + flags out)
// Flow: IDLE captures operands, MUL runs a radix-2 shift-add over the
// multiplier significand (LSB first), RND registers the rounded result,
// DONE presents it until out_ready.
module fp_mul_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic         clk,
    input  logic         rst,
    fp_mul_seq_if.slave  bus
);
    localparam int W     = EXP_W + MAN_W + 1;
    localparam int SW    = MAN_W + 1;
    localparam int PW    = 2 * SW;
    localparam int CNT_W = $clog2(SW + 1);

    state_t           state, state_nxt;
    logic [W-1:0]     a_q, b_q;
    logic             rm_q;
    logic [PW-1:0]    acc, mcand;
    logic [SW-1:0]    mplier;
    logic [CNT_W-1:0] count;
    logic             mul_done;

    logic [W-1:0]     c_q, rn_c;
    logic             of_q, uf_q, nv_q, nx_q;
    logic             rn_of, rn_uf, rn_nv, rn_nx;

    // MUL spends SW cycles accumulating and one more cycle with the full
    // product settled in acc before handing over to RND.
    assign mul_done = (count == CNT_W'(SW));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = MUL;
            MUL:     if (mul_done)      state_nxt = RND;
            RND:                        state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            rm_q   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            c_q    <= '0;
            of_q   <= 1'b0;
            uf_q   <= 1'b0;
            nv_q   <= 1'b0;
            nx_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q    <= bus.a;
                    b_q    <= bus.b;
                    rm_q   <= bus.rm;
                    acc    <= '0;
                    // Hidden bit is dropped for exp == 0 so denormals multiply as zero.
                    mcand  <= {{SW{1'b0}}, |bus.a[W-2:MAN_W], bus.a[MAN_W-1:0]};
                    mplier <= {|bus.b[W-2:MAN_W], bus.b[MAN_W-1:0]};
                    count  <= '0;
                    of_q   <= 1'b0;
                    uf_q   <= 1'b0;
                    nv_q   <= 1'b0;
                    nx_q   <= 1'b0;
                end
                MUL: if (!mul_done) begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                end
                RND: begin
                    c_q  <= rn_c;
                    of_q <= rn_of;
                    uf_q <= rn_uf;
                    nv_q <= rn_nv;
                    nx_q <= rn_nx;
                end
                default: ;
            endcase
        end
    end

    fp_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .a         (a_q),
        .b         (b_q),
        .rm        (rm_q),
        .prod      (acc),
        .c         (rn_c),
        .overflow  (rn_of),
        .underflow (rn_uf),
        .invalid   (rn_nv),
        .inexact   (rn_nx)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.c         = c_q;
    assign bus.overflow  = of_q;
    assign bus.underflow = uf_q;
    assign bus.invalid   = nv_q;
    assign bus.inexact   = nx_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq (single-precision widths). The driver
// pushes a reference result per accepted operation; the monitor pops and
// compares whenever a result is handed over.
module tb_fp_mul_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    // Accept at edge k, out_valid visible after edge k+MAN_W+3.
    localparam int LAT   = MAN_W + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_mul_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Reference: exact integer product of significands, rounded by comparing
    // the discarded remainder against half an ulp. Result {c, of, uf, nv, nx}.
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic m);
        logic sign;
        int ex, ey, e, sh;
        logic [22:0] fx, fy;
        logic xnan, ynan, xinf, yinf, xz, yz, nx;
        longint unsigned p, q, rem, half;
        sign = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = x[22:0];
        fy = y[22:0];
        xnan = (ex == 255) && (fx != 0);
        ynan = (ey == 255) && (fy != 0);
        xinf = (ex == 255) && (fx == 0);
        yinf = (ey == 255) && (fy == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xnan || ynan || (xinf && yz) || (yinf && xz)) return {32'h7FC00000, 4'b0010};
        if (xinf || yinf) return {sign, 8'hFF, 23'h0, 4'b0000};
        if (xz || yz) return {sign, 31'h0, 4'b0000};
        p = (64'(fx) + 64'h800000) * (64'(fy) + 64'h800000);
        e = ex + ey - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e++; end
        else sh = 23;
        q = p >> sh;
        rem = p - (q << sh);
        half = 64'd1 << (sh - 1);
        nx = (rem != 0);
        if (!m && ((rem > half) || ((rem == half) && q[0]))) q++;
        if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
        if (e >= 255) return m ? {sign, 8'hFE, 23'h7FFFFF, 4'b1001} : {sign, 8'hFF, 23'h0, 4'b1001};
        if (e <= 0) return {sign, 31'h0, 4'b0101};
        return {sign, 8'(e), q[22:0], 3'b000, nx};
    endfunction

    function automatic logic [31:0] rnd_op();
        int k;
        logic [7:0] e;
        logic [22:0] f;
        k = int'($urandom_range(0, 9));
        if (k == 0)      e = 8'd0;
        else if (k == 1) e = 8'd255;
        else if (k == 2) e = 8'($urandom_range(1, 20));
        else if (k == 3) e = 8'($urandom_range(235, 254));
        else             e = 8'($urandom_range(100, 154));
        f = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // Monitor: one pop per result handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(bus.c), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [35:0] w;
                w = exp_q.pop_front();
                check("result", 64'({bus.c, bus.overflow, bus.underflow, bus.invalid, bus.inexact}), 64'(w));
            end
        end
    end

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic trm, input int hold);
        int n;
        logic ir_seen;
        logic [35:0] snap;
        n = 0;
        while (!bus.in_ready && n < 200) begin @(posedge clk); #1; n++; end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        bus.a = ta;
        bus.b = tb;
        bus.rm = trm;
        bus.in_valid = 1'b1;
        exp_q.push_back(ref_mul(ta, tb, trm));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        ir_seen = 1'b0;
        while (!bus.out_valid && n < 200) begin
            if (bus.in_ready) ir_seen = 1'b1;
            @(posedge clk); #1; n++;
        end
        check("latency", 64'(n), 64'(LAT));
        check("in_ready_busy", 64'(ir_seen), 64'd0);
        snap = {bus.c, bus.overflow, bus.underflow, bus.invalid, bus.inexact};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_stable", 64'({bus.c, bus.overflow, bus.underflow, bus.invalid, bus.inexact}), 64'(snap));
            check("hold_ctrl", 64'({bus.out_valid, bus.in_ready}), 64'b10);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.rm = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        check("reset_out", 64'({bus.c, bus.overflow, bus.underflow, bus.invalid, bus.inexact}), 64'd0);
        rst = 1'b0;

        do_op(32'h3FC00000, 32'h40000000, 1'b0, 0);
        do_op(32'h3F800001, 32'h3F800001, 1'b0, 0);
        do_op(32'h3F800800, 32'h3F800800, 1'b0, 0);
        do_op(32'h3F800800, 32'h3F800800, 1'b1, 0);
        do_op(32'h7F000000, 32'h40000000, 1'b0, 0);
        do_op(32'h7F000000, 32'h40000000, 1'b1, 0);
        do_op(32'h7F800000, 32'h00000000, 1'b0, 0);
        do_op(32'hC0400000, 32'h00000000, 1'b0, 0);
        do_op(32'hFF800000, 32'h40000000, 1'b0, 0);
        do_op(32'h00800000, 32'h3F000000, 1'b0, 0);
        do_op(32'h3F800001, 32'h3F800001, 1'b0, 10);

        // Reset in the fifth MUL cycle discards the operation.
        bus.a = 32'h40400000;
        bus.b = 32'h40400000;
        bus.rm = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset_ctrl", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        do_op(32'h3FC00000, 32'h40000000, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
